// File: rtl/user_rom_arbiter.sv
// -----------------------------------------------------------------------------
// obi_pkg: minimal OBI configuration and channel types used as the defaults
// for the user-domain ROM arbiter.
//
// user_rom_arbiter: shares one read-only OBI subordinate (the user-domain ROM)
// between NumMgr OBI managers.
//   - Round-robin arbitration on the request channel.
//   - Zero added latency on both request and response paths.
//   - An in-order tag FIFO remembers which manager owns each outstanding
//     transaction, so responses are routed back to their originator.
//
// Ports:
//   clk_i        clock
//   rst_i        asynchronous, active-high reset
//   mgr_req_i    per-manager OBI requests   [NumMgr]
//   mgr_rsp_o    per-manager OBI responses  [NumMgr]
//   sbr_req_o    OBI request to the ROM
//   sbr_rsp_i    OBI response from the ROM
//   busy_o       high while any transaction is outstanding
//   unexp_rsp_o  sticky: an rvalid arrived with nothing outstanding
//
// Handshake: an address-phase transfer happens in a cycle where req and gnt
// are both high; a manager keeps req and its a-channel stable until gnt.
// A response transfer happens in any cycle with rvalid high (no ready).
// -----------------------------------------------------------------------------
package obi_pkg;

    typedef struct packed {
        int unsigned addr_width;
        int unsigned data_width;
        int unsigned id_width;
    } obi_cfg_t;

    localparam obi_cfg_t ObiDefaultConfig = '{
        addr_width: 32,
        data_width: 32,
        id_width:   1
    };

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [0:0]  aid;
    } obi_a_chan_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [0:0]  rid;
        logic        err;
        logic [0:0]  r_optional;
    } obi_r_chan_t;

    typedef struct packed {
        logic        req;
        obi_a_chan_t a;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        obi_r_chan_t r;
    } obi_rsp_t;

endpackage

module user_rom_arbiter #(
    parameter obi_pkg::obi_cfg_t ObiCfg    = obi_pkg::ObiDefaultConfig,
    parameter type               obi_req_t = obi_pkg::obi_req_t,
    parameter type               obi_rsp_t = obi_pkg::obi_rsp_t,
    parameter int unsigned       NumMgr    = 2,
    parameter int unsigned       MaxTrans  = 4
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  obi_req_t mgr_req_i [NumMgr],
    output obi_rsp_t mgr_rsp_o [NumMgr],
    output obi_req_t sbr_req_o,
    input  obi_rsp_t sbr_rsp_i,
    output logic     busy_o,
    output logic     unexp_rsp_o
);

    localparam int unsigned IdxW = (NumMgr > 1) ? $clog2(NumMgr) : 1;
    localparam int unsigned CntW = $clog2(MaxTrans + 1);
    localparam int unsigned PtrW = $clog2(MaxTrans);

    localparam logic [CntW-1:0] CntFull = CntW'(MaxTrans);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumMgr - 1);

    // Elaboration-time parameter sanity checks.
    if (NumMgr < 2 || NumMgr > 8) begin : g_bad_num_mgr
        $error("user_rom_arbiter: NumMgr must be in 2..8");
    end
    if (MaxTrans < 2 || (MaxTrans & (MaxTrans - 1)) != 0) begin : g_bad_max_trans
        $error("user_rom_arbiter: MaxTrans must be a power of 2 and >= 2");
    end
    if (ObiCfg.data_width == 0) begin : g_bad_cfg
        $error("user_rom_arbiter: ObiCfg.data_width must be non-zero");
    end

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [IdxW-1:0] rr_ptr;
    logic [CntW-1:0] count;
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic [IdxW-1:0] tag_mem [MaxTrans];
    logic            unexp_q;

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    logic            full;
    logic            found;
    logic [IdxW-1:0] win_idx;
    int unsigned     cand;
    logic [IdxW-1:0] cand_idx;

    assign full = (count == CntFull);

    // Scan from the round-robin pointer upward, wrapping; the first requester
    // wins. Reset and a full tag FIFO both suppress any winner, which in turn
    // forces sbr_req_o.req and every gnt low.
    always_comb begin
        found    = 1'b0;
        win_idx  = '0;
        cand     = 0;
        cand_idx = '0;
        if (!rst_i && !full) begin
            for (int unsigned k = 0; k < NumMgr; k++) begin
                cand     = (32'(rr_ptr) + k) % NumMgr;
                cand_idx = IdxW'(cand);
                if (!found && mgr_req_i[cand_idx].req) begin
                    found   = 1'b1;
                    win_idx = cand_idx;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Handshake / response bookkeeping
    // -------------------------------------------------------------------------
    logic            push;
    logic            pop;
    logic            empty;
    logic [IdxW-1:0] head_idx;

    assign empty    = (count == '0);
    assign push     = found && sbr_rsp_i.gnt;
    // An rvalid with nothing outstanding is dropped rather than popped.
    assign pop      = !rst_i && sbr_rsp_i.rvalid && !empty;
    assign head_idx = tag_mem[rd_ptr];

    // -------------------------------------------------------------------------
    // Output muxing (pure combinational, no added latency)
    // -------------------------------------------------------------------------
    always_comb begin
        sbr_req_o = '0;
        if (found) begin
            sbr_req_o.req = 1'b1;
            sbr_req_o.a   = mgr_req_i[win_idx].a;
        end

        for (int unsigned m = 0; m < NumMgr; m++) begin
            mgr_rsp_o[m] = '0;
        end
        if (found) begin
            mgr_rsp_o[win_idx].gnt = sbr_rsp_i.gnt;
        end
        if (pop) begin
            mgr_rsp_o[head_idx].rvalid = 1'b1;
            mgr_rsp_o[head_idx].r      = sbr_rsp_i.r;
        end
    end

    assign busy_o      = !empty;
    assign unexp_rsp_o = unexp_q;

    // -------------------------------------------------------------------------
    // Sequential state
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr  <= '0;
            count   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            unexp_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                rr_ptr <= (win_idx == LastIdx) ? '0 : win_idx + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // Push and pop in the same cycle leave the count unchanged.
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (sbr_rsp_i.rvalid && empty) begin
                unexp_q <= 1'b1;
            end
        end
    end

    // Tag storage needs no reset: entries are only read once written, as
    // guarded by the count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            tag_mem[wr_ptr] <= win_idx;
        end
    end

endmodule
